registers: RTL and testbench

REGISTERS -- requirements
Module: registers

---
 rtl/registers.sv | 58 +++++
 tb/tb_registers.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/registers.sv
// registers: eight parallel WIDTH-bit storage slots with a common load enable.
// All slots load together on a rising clk edge when en is high and hold
// otherwise. rst is asynchronous and active-low; while it is low every slot
// reads zero. Each output comes straight from its slot's flip-flops.
module registers #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic [WIDTH-1:0] i4,
    input  logic [WIDTH-1:0] i5,
    input  logic [WIDTH-1:0] i6,
    input  logic [WIDTH-1:0] i7,
    output logic [WIDTH-1:0] o0,
    output logic [WIDTH-1:0] o1,
    output logic [WIDTH-1:0] o2,
    output logic [WIDTH-1:0] o3,
    output logic [WIDTH-1:0] o4,
    output logic [WIDTH-1:0] o5,
    output logic [WIDTH-1:0] o6,
    output logic [WIDTH-1:0] o7
);

    logic [WIDTH-1:0] slot [8];

    // Load all eight slots in parallel on en; clear them asynchronously on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 8; k++) begin
                slot[k] <= '0;
            end
        end else if (en) begin
            slot[0] <= i0;
            slot[1] <= i1;
            slot[2] <= i2;
            slot[3] <= i3;
            slot[4] <= i4;
            slot[5] <= i5;
            slot[6] <= i6;
            slot[7] <= i7;
        end
    end

    assign o0 = slot[0];
    assign o1 = slot[1];
    assign o2 = slot[2];
    assign o3 = slot[3];
    assign o4 = slot[4];
    assign o5 = slot[5];
    assign o6 = slot[6];
    assign o7 = slot[7];

endmodule

// File: tb/tb_registers.sv
// Directed bench for the registers block: reset, parallel load, hold,
// extreme values, asynchronous mid-operation reset and input changes
// without a clock edge.
module tb_registers;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en  = 1'b0;
    bit           clk_run = 1'b1;
    logic [W-1:0] in_v [8];
    logic [W-1:0] i0, i1, i2, i3, i4, i5, i6, i7;
    logic [W-1:0] o0, o1, o2, o3, o4, o5, o6, o7;
    logic [W-1:0] obs [8];
    logic [W-1:0] exp_v [8];

    int vectors = 0;
    int miscompares = 0;

    assign i0 = in_v[0];
    assign i1 = in_v[1];
    assign i2 = in_v[2];
    assign i3 = in_v[3];
    assign i4 = in_v[4];
    assign i5 = in_v[5];
    assign i6 = in_v[6];
    assign i7 = in_v[7];

    assign obs[0] = o0;
    assign obs[1] = o1;
    assign obs[2] = o2;
    assign obs[3] = o3;
    assign obs[4] = o4;
    assign obs[5] = o5;
    assign obs[6] = o6;
    assign obs[7] = o7;

    registers #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en),
        .i0(i0), .i1(i1), .i2(i2), .i3(i3), .i4(i4), .i5(i5), .i6(i6), .i7(i7),
        .o0(o0), .o1(o1), .o2(o2), .o3(o3), .o4(o4), .o5(o5), .o6(o6), .o7(o7)
    );

    // Free-running clock that can be frozen for the no-edge scenario.
    always #5 if (clk_run) clk = ~clk;

    task automatic test_reset();
        for (int k = 0; k < 8; k++) in_v[k] = 8'hFF;
        en = 1'b1;
        #2 rst = 1'b0;
        #1;
        for (int k = 0; k < 8; k++) exp_v[k] = 8'h00;
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (obs[k] !== exp_v[k]) begin
                miscompares++;
                $display("FAIL reset_assert slot %0d: got %h expected %h", k, obs[k], exp_v[k]);
            end
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 8; k++) begin
                vectors++;
                if (obs[k] !== exp_v[k]) begin
                    miscompares++;
                    $display("FAIL reset_hold edge %0d slot %0d: got %h expected %h", c, k, obs[k], exp_v[k]);
                end
            end
        end
        @(negedge clk);
        en = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (obs[k] !== exp_v[k]) begin
                miscompares++;
                $display("FAIL reset_release slot %0d: got %h expected %h", k, obs[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_parallel_load();
        @(negedge clk);
        en = 1'b1;
        for (int k = 0; k < 8; k++) in_v[k] = W'(k + 1);
        #1;
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (obs[k] !== 8'h00) begin
                miscompares++;
                $display("FAIL load_before_edge slot %0d: got %h expected %h", k, obs[k], 8'h00);
            end
        end
        @(posedge clk);
        #1;
        exp_v = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (obs[k] !== exp_v[k]) begin
                miscompares++;
                $display("FAIL load_after_edge slot %0d: got %h expected %h", k, obs[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        en = 1'b0;
        for (int k = 0; k < 8; k++) in_v[k] = 8'hAA;
        exp_v = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 8; k++) begin
                vectors++;
                if (obs[k] !== exp_v[k]) begin
                    miscompares++;
                    $display("FAIL hold edge %0d slot %0d: got %h expected %h", c, k, obs[k], exp_v[k]);
                end
            end
        end
    endtask

    task automatic test_reload_extremes();
        @(negedge clk);
        en = 1'b1;
        in_v = '{8'h00, 8'hFF, 8'h80, 8'h7F, 8'h55, 8'hAA, 8'h01, 8'hFE};
        @(posedge clk);
        #1;
        exp_v = '{8'h00, 8'hFF, 8'h80, 8'h7F, 8'h55, 8'hAA, 8'h01, 8'hFE};
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (obs[k] !== exp_v[k]) begin
                miscompares++;
                $display("FAIL reload slot %0d: got %h expected %h", k, obs[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        en = 1'b1;
        in_v = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87};
        @(posedge clk);
        #1;
        exp_v = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87};
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (obs[k] !== exp_v[k]) begin
                miscompares++;
                $display("FAIL b2b_first slot %0d: got %h expected %h", k, obs[k], exp_v[k]);
            end
        end
        @(negedge clk);
        in_v = '{8'hC3, 8'h3C, 8'h99, 8'h66, 8'hF0, 8'h0F, 8'hE7, 8'h18};
        @(posedge clk);
        #1;
        exp_v = '{8'hC3, 8'h3C, 8'h99, 8'h66, 8'hF0, 8'h0F, 8'hE7, 8'h18};
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (obs[k] !== exp_v[k]) begin
                miscompares++;
                $display("FAIL b2b_second slot %0d: got %h expected %h", k, obs[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_no_clock();
        @(negedge clk);
        clk_run = 1'b0;
        en = 1'b1;
        in_v = '{8'h5A, 8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        #20;
        in_v = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        #20;
        exp_v = '{8'hC3, 8'h3C, 8'h99, 8'h66, 8'hF0, 8'h0F, 8'hE7, 8'h18};
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (obs[k] !== exp_v[k]) begin
                miscompares++;
                $display("FAIL no_clock slot %0d: got %h expected %h", k, obs[k], exp_v[k]);
            end
        end
        en = 1'b0;
        clk_run = 1'b1;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        en = 1'b1;
        in_v = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        for (int k = 0; k < 8; k++) exp_v[k] = 8'h00;
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (obs[k] !== exp_v[k]) begin
                miscompares++;
                $display("FAIL async_reset slot %0d: got %h expected %h", k, obs[k], exp_v[k]);
            end
        end
        @(negedge clk);
        en = 1'b0;
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 8; k++) begin
                vectors++;
                if (obs[k] !== exp_v[k]) begin
                    miscompares++;
                    $display("FAIL post_reset_hold edge %0d slot %0d: got %h expected %h", c, k, obs[k], exp_v[k]);
                end
            end
        end
    endtask

    task automatic test_reset_same_edge();
        @(negedge clk);
        en = 1'b1;
        in_v = '{8'h9A, 8'hBC, 8'hDE, 8'hF1, 8'h23, 8'h45, 8'h67, 8'h89};
        @(posedge clk);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 8; k++) exp_v[k] = 8'h00;
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (obs[k] !== exp_v[k]) begin
                miscompares++;
                $display("FAIL reset_same_edge slot %0d: got %h expected %h", k, obs[k], exp_v[k]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_v = '{8'h9A, 8'hBC, 8'hDE, 8'hF1, 8'h23, 8'h45, 8'h67, 8'h89};
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (obs[k] !== exp_v[k]) begin
                miscompares++;
                $display("FAIL load_after_release slot %0d: got %h expected %h", k, obs[k], exp_v[k]);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) in_v[k] = '0;
        test_reset();
        test_parallel_load();
        test_hold();
        test_reload_extremes();
        test_back_to_back();
        test_no_clock();
        test_async_reset();
        test_reset_same_edge();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
